// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with RW/RO/W1C words, byte strobes, HW update port and bypassed 1-cycle reads
module reg_file_mp #(
    parameter int                    DataWidth  = 32,
    parameter int                    NumWords   = 64,
    parameter int                    NumRdPorts = 2,
    parameter logic [2*NumWords-1:0] WordMode   = '0,
    parameter logic [DataWidth-1:0]  ResetVal   = '0,
    localparam int                   AW         = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int                   SW         = DataWidth / 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [AW-1:0]                  wa,
    input  logic [DataWidth-1:0]           wd,
    input  logic [SW-1:0]                  wstrb,
    output logic                           werr,
    input  logic                           hw_we,
    input  logic [AW-1:0]                  hw_wa,
    input  logic [DataWidth-1:0]           hw_wd,
    input  logic [NumRdPorts-1:0]          re,
    input  logic [NumRdPorts*AW-1:0]       ra,
    output logic [NumRdPorts*DataWidth-1:0] rd,
    output logic [NumRdPorts-1:0]          rvalid,
    output logic [NumRdPorts-1:0]          rerr
);
    logic [DataWidth-1:0] mem   [NumWords];
    logic [DataWidth-1:0] nxt   [NumWords];
    logic [DataWidth-1:0] rdata [NumRdPorts];
    logic [DataWidth-1:0] mask;
    logic [NumRdPorts-1:0] ra_ok;
    logic wa_ok;
    logic wa_ro;

    // expand byte strobes into a bit mask
    always_comb begin
        mask = '0;
        for (int b = 0; b < SW; b++) mask[8*b +: 8] = {8{wstrb[b]}};
    end

    // next word values: SW write first, HW update applied on top so HW wins per bit
    always_comb begin
        wa_ok = 32'(wa) < NumWords;
        wa_ro = 1'b0;
        for (int i = 0; i < NumWords; i++) begin
            nxt[i] = mem[i];
            if (we && wa == AW'(i)) begin
                wa_ro = WordMode[2*i +: 2] == 2'b01;
                if (WordMode[2*i +: 2] == 2'b10) nxt[i] = nxt[i] & ~(wd & mask);
                else if (WordMode[2*i +: 2] != 2'b01) nxt[i] = (nxt[i] & ~mask) | (wd & mask);
            end
            if (hw_we && hw_wa == AW'(i)) nxt[i] = (WordMode[2*i +: 2] == 2'b10) ? (nxt[i] | hw_wd) : hw_wd;
        end
    end

    // read muxes look at next-state values so same-cycle writes are bypassed; out-of-range reads give 0
    always_comb begin
        for (int p = 0; p < NumRdPorts; p++) begin
            ra_ok[p] = 32'(ra[p*AW +: AW]) < NumWords;
            rdata[p] = '0;
            for (int i = 0; i < NumWords; i++)
                if (ra[p*AW +: AW] == AW'(i)) rdata[p] = nxt[i];
        end
    end

    // state and registered read/error outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumWords; i++) mem[i] <= ResetVal;
            rd     <= '0;
            rvalid <= '0;
            rerr   <= '0;
            werr   <= 1'b0;
        end else begin
            for (int i = 0; i < NumWords; i++) mem[i] <= nxt[i];
            werr <= we && (!wa_ok || wa_ro);
            for (int p = 0; p < NumRdPorts; p++) begin
                rvalid[p] <= re[p];
                rerr[p]   <= re[p] && !ra_ok[p];
                if (re[p]) rd[p*DataWidth +: DataWidth] <= rdata[p];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized scoreboard bench for reg_file_mp against a bit-level reference model
module tb_reg_file_mp;
    localparam int NW = 48;
    localparam logic [31:0] RV = 32'hA5A5_0000;

    function automatic logic [2*NW-1:0] modes();
        logic [2*NW-1:0] m;
        m = '0;
        for (int i = 0; i < NW; i++)
            m[2*i +: 2] = (i == 2 || i == 3) ? 2'd0 : (i == 5) ? 2'd2 : (i == 7) ? 2'd1 : 2'(i % 4);
        return m;
    endfunction
    localparam logic [2*NW-1:0] WM = modes();

    logic        clk = 0;
    logic        reset, we, hw_we, werr;
    logic [5:0]  wa, hw_wa;
    logic [31:0] wd, hw_wd;
    logic [3:0]  wstrb;
    logic [1:0]  re, rvalid, rerr;
    logic [11:0] ra;
    logic [63:0] rd;

    reg_file_mp #(.DataWidth(32), .NumWords(NW), .NumRdPorts(2), .WordMode(WM), .ResetVal(RV)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .wstrb(wstrb), .werr(werr),
        .hw_we(hw_we), .hw_wa(hw_wa), .hw_wd(hw_wd), .re(re), .ra(ra), .rd(rd),
        .rvalid(rvalid), .rerr(rerr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  e;
        logic [63:0] d;
        logic        w;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [NW];
    logic [31:0] last  [2];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [1:0] mode_of(int i);
        return WM[2*i +: 2];
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // reference model: applies the cycle's requests at the edge and queues what the DUT must show
    task automatic tick();
        exp_t x;
        int a;
        @(posedge clk);
        x = '0;
        if (reset) begin
            for (int i = 0; i < NW; i++) model[i] = RV;
            last[0] = 0;
            last[1] = 0;
        end else begin
            if (we) begin
                if (wa >= NW || mode_of(int'(wa)) == 2'd1) x.w = 1;
                else
                    for (int k = 0; k < 32; k++)
                        if (wstrb[k/8]) begin
                            if (mode_of(int'(wa)) == 2'd2) begin
                                if (wd[k]) model[wa][k] = 1'b0;
                            end else model[wa][k] = wd[k];
                        end
            end
            if (hw_we && hw_wa < NW)
                model[hw_wa] = (mode_of(int'(hw_wa)) == 2'd2) ? (model[hw_wa] | hw_wd) : hw_wd;
            for (int p = 0; p < 2; p++) begin
                a = int'(ra[p*6 +: 6]);
                if (re[p]) begin
                    x.v[p] = 1;
                    if (a < NW) last[p] = model[a];
                    else begin
                        last[p] = 0;
                        x.e[p] = 1;
                    end
                end
            end
        end
        x.d = {last[1], last[0]};
        q.push_back(x);
        #1;
    endtask

    task automatic idle();
        reset = 0; we = 0; hw_we = 0; re = 0;
    endtask

    task automatic chk_rd(string n, int p, logic [31:0] exp);
        @(negedge clk);
        chk(n, rd[p*32 +: 32], exp);
    endtask

    task automatic rd1(int a);
        idle();
        re = 2'b01;
        ra = {6'd0, 6'(a)};
        tick();
    endtask

    // monitor: every output cycle is compared against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rvalid", 64'(rvalid), 64'(e.v));
            chk("rerr", 64'(rerr), 64'(e.e));
            chk("rd", rd, e.d);
            chk("werr", 64'(werr), 64'(e.w));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1; wa = 0; wd = 0; wstrb = 0; hw_wa = 0; hw_wd = 0; ra = 0;
        tick();
        tick();
        for (int w = 0; w < NW; w++) begin
            idle();
            re = 2'b11;
            ra = {6'(NW - 1 - w), 6'(w)};
            tick();
            if (w == 0) chk_rd("reset_val_p0", 0, RV);
            if (w == 1) chk_rd("reset_val_p1", 1, RV);
        end
        idle(); we = 1; wa = 3; wd = 0; wstrb = 4'hF; tick();
        wd = 32'hAABBCCDD; wstrb = 4'b0101; tick();
        rd1(3); chk_rd("rw_strobe", 0, 32'h00BB00DD);
        idle(); we = 1; wa = 3; wd = 32'hFFFFFFFF; wstrb = 0; tick();
        rd1(3); chk_rd("strobe_zero_noop", 0, 32'h00BB00DD);
        idle(); we = 1; wa = 5; wd = 32'hFFFFFFFF; wstrb = 4'hF; tick();
        idle(); hw_we = 1; hw_wa = 5; hw_wd = 32'hFF00FF00; tick();
        idle(); we = 1; wa = 5; wd = 32'h0F000F00; wstrb = 4'hF;
        hw_we = 1; hw_wa = 5; hw_wd = 32'h01000000; re = 2'b01; ra = {6'd0, 6'd5}; tick();
        chk_rd("w1c_collision", 0, 32'hF100F000);
        idle(); we = 1; wa = 7; wd = 32'h12345678; wstrb = 4'hF; tick();
        @(negedge clk); chk("ro_werr", 64'(werr), 64'd1);
        rd1(7); chk_rd("ro_unchanged", 0, RV);
        idle(); hw_we = 1; hw_wa = 7; hw_wd = 32'h55; tick();
        rd1(7); chk_rd("ro_hw_write", 0, 32'h55);
        idle(); we = 1; wa = 2; wd = 32'hDEADBEEF; wstrb = 4'hF; re = 2'b11; ra = {6'd2, 6'd2}; tick();
        chk_rd("bypass_p0", 0, 32'hDEADBEEF);
        chk("bypass_p1", 64'(rd[63:32]), 64'h0DEADBEEF);
        idle(); re = 2'b01; ra = {6'd0, 6'd50}; tick();
        @(negedge clk); chk("range_rerr", 64'(rerr), 64'd1);
        chk("range_rd", 64'(rd[31:0]), 64'd0);
        idle(); we = 1; wa = 50; wd = 32'h0; wstrb = 4'hF; hw_we = 1; hw_wa = 50; hw_wd = 32'h1; tick();
        @(negedge clk); chk("range_werr", 64'(werr), 64'd1);
        rd1(2); chk_rd("range_no_change", 0, 32'hDEADBEEF);
        idle(); re = 2'b01; ra = {6'd0, 6'd2}; tick();
        idle(); reset = 1; we = 1; wa = 2; wd = 32'h0; wstrb = 4'hF; re = 2'b11; tick();
        @(negedge clk); chk("reset_rvalid", 64'(rvalid), 64'd0);
        rd1(2); chk_rd("reset_word", 0, RV);
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom % 64) == 0;
            we = $urandom % 2;
            wa = 6'($urandom_range(0, 51));
            wd = $urandom;
            wstrb = 4'($urandom);
            hw_we = ($urandom % 3) == 0;
            hw_wa = ($urandom % 4 == 0) ? wa : 6'($urandom_range(0, 51));
            hw_wd = $urandom;
            re = 2'($urandom);
            ra = {6'($urandom_range(0, 51)), ($urandom % 3 == 0) ? wa : 6'($urandom_range(0, 51))};
            tick();
        end
        idle();
        tick();
        tick();
        @(negedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
